// File: rtl/spart_tx_if.sv
// Processor-side bus of the SPART transmitter: byte/write strobe in, status and serial line out.
`timescale 1ns/1ps
interface spart_tx_if #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
);
    logic [DIV_W-1:0]  baud_div;
    logic [DATA_W-1:0] tx_data;
    logic              tx_wr;
    logic              tbr;
    logic              tx_busy;
    logic              txd;

    modport master (
        output baud_div, tx_data, tx_wr,
        input  tbr, tx_busy, txd
    );

    modport slave (
        input  baud_div, tx_data, tx_wr,
        output tbr, tx_busy, txd
    );
endinterface

// File: rtl/spart_tx.sv
// SPART transmitter: holding register + shifter producing 8N1 frames on a registered txd,
// allowing back-to-back frames with no idle gap between a stop bit and the next start bit.
`timescale 1ns/1ps
module spart_tx #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    spart_tx_if.slave  bus
);
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state_reg, state_next;
    logic [DATA_W-1:0] hold_reg, hold_next;
    logic              hold_full_reg, hold_full_next;
    logic [DATA_W-1:0] shift_reg, shift_next;
    logic [DIV_W-1:0]  div_reg, div_next;
    logic [DIV_W-1:0]  cnt_reg, cnt_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic              txd_reg, txd_next;
    logic              busy_reg, busy_next;

    logic              write_accept;
    logic              load_shifter;
    logic              bit_done;
    logic [DIV_W-1:0]  div_clamped;
    logic [IDX_W-1:0]  idx_up;
    logic [IDX_W-1:0]  idx_pick;
    logic [DATA_W-1:0] pick_vec;
    logic              pick_bit;

    assign write_accept = bus.tx_wr & ~hold_full_reg;
    assign bit_done     = (cnt_reg == div_reg - DIV_W'(1));
    // A divisor below 2 would leave no room for the counter wrap; clamp it.
    assign div_clamped  = (bus.baud_div < DIV_W'(2)) ? DIV_W'(2) : bus.baud_div;

    // The next data bit to drive: bit 0 when leaving START, idx+1 while in DATA.
    assign idx_up   = idx_reg + IDX_W'(1);
    assign idx_pick = (state_reg == DATA) ? idx_up : '0;

    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_pick
            assign pick_vec[gi] = shift_reg[gi] & (idx_pick == IDX_W'(gi));
        end
    endgenerate
    assign pick_bit = |pick_vec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            hold_reg      <= '0;
            hold_full_reg <= 1'b0;
            shift_reg     <= '0;
            div_reg       <= DIV_W'(2);
            cnt_reg       <= '0;
            idx_reg       <= '0;
            txd_reg       <= 1'b1;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            hold_reg      <= hold_next;
            hold_full_reg <= hold_full_next;
            shift_reg     <= shift_next;
            div_reg       <= div_next;
            cnt_reg       <= cnt_next;
            idx_reg       <= idx_next;
            txd_reg       <= txd_next;
            busy_reg      <= busy_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        shift_next   = shift_reg;
        div_next     = div_reg;
        cnt_next     = cnt_reg;
        idx_next     = idx_reg;
        txd_next     = txd_reg;
        busy_next    = busy_reg;
        load_shifter = 1'b0;

        case (state_reg)
            IDLE: begin
                txd_next  = 1'b1;
                busy_next = 1'b0;
                cnt_next  = '0;
                if (hold_full_reg) begin
                    load_shifter = 1'b1;
                end
            end
            START: begin
                if (bit_done) begin
                    cnt_next   = '0;
                    idx_next   = '0;
                    txd_next   = pick_bit;
                    state_next = DATA;
                end else begin
                    cnt_next = cnt_reg + DIV_W'(1);
                end
            end
            DATA: begin
                if (bit_done) begin
                    cnt_next = '0;
                    if (idx_reg == IDX_LAST) begin
                        txd_next   = 1'b1;
                        state_next = STOP;
                    end else begin
                        idx_next = idx_up;
                        txd_next = pick_bit;
                    end
                end else begin
                    cnt_next = cnt_reg + DIV_W'(1);
                end
            end
            STOP: begin
                if (bit_done) begin
                    cnt_next = '0;
                    if (hold_full_reg) begin
                        load_shifter = 1'b1;
                    end else begin
                        txd_next   = 1'b1;
                        busy_next  = 1'b0;
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + DIV_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                txd_next   = 1'b1;
                busy_next  = 1'b0;
            end
        endcase

        // Holding register empties into the shifter; the divisor is frozen for the whole frame.
        if (load_shifter) begin
            shift_next = hold_reg;
            div_next   = div_clamped;
            cnt_next   = '0;
            idx_next   = '0;
            txd_next   = 1'b0;
            busy_next  = 1'b1;
            state_next = START;
        end
    end

    always_comb begin
        hold_next      = hold_reg;
        hold_full_next = hold_full_reg;
        if (load_shifter) begin
            hold_full_next = 1'b0;
        end else if (write_accept) begin
            hold_next      = bus.tx_data;
            hold_full_next = 1'b1;
        end
    end

    assign bus.tbr     = ~hold_full_reg;
    assign bus.tx_busy = busy_reg;
    assign bus.txd     = txd_reg;

endmodule
